// File: rtl/seq_nr_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential non-restoring divider.
interface seq_nr_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// Unsigned non-restoring divider: one quotient bit per cycle through a single shared
// ripple add/sub unit, with operand capture, final remainder correction and start/done handshake.
module n_bit_adder_sub #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    always_comb begin
        logic         c;
        logic         c_msb;
        logic [n-1:0] b_x;
        b_x   = b ^ {n{c_in}};
        c     = c_in;
        c_msb = c_in;
        sum   = '0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) c_msb = c;
            sum[i] = a[i] ^ b_x[i] ^ c;
            c      = (a[i] & b_x[i]) | (c & (a[i] ^ b_x[i]));
        end
        c_out    = c;
        overflow = c ^ c_msb;
    end
endmodule

module seq_nr_divider #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_nr_divider_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    m_q, m_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    add_a;
    logic          add_sub;
    logic [N:0]    add_sum;
    logic          unused_c_out;
    logic          unused_overflow;

    // Single shared unit: c_in=1 subtracts M, c_in=0 adds M.
    n_bit_adder_sub #(.n(N + 1)) u_addsub (
        .a        (add_a),
        .b        (m_q),
        .c_in     (add_sub),
        .sum      (add_sum),
        .c_out    (unused_c_out),
        .overflow (unused_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        add_a       = a_q;
        add_sub     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    m_d     = {1'b0, bus.divisor};
                    a_d     = '0;
                    count_d = '0;
                    dbz_d   = 1'b0;
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                // Shift {A,Q} left, then subtract M on a non-negative A or add it back on a negative one.
                add_a   = {a_q[N-1:0], q_q[N-1]};
                add_sub = ~a_q[N];
                a_d     = add_sum;
                q_d     = {q_q[N-2:0], ~add_sum[N]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = FIX;
            end
            FIX: begin
                // A negative partial remainder needs one restoring add of M.
                add_sub = 1'b0;
                if (a_q[N]) a_d = add_sum;
                quotient_d  = q_q;
                remainder_d = a_q[N] ? add_sum[N-1:0] : a_q[N-1:0];
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q == ITER) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_nr_divider.sv
// Randomized bench for seq_nr_divider at N=8 and N=32 against an arithmetic reference model.
module tb_seq_nr_divider;
    localparam int LIMIT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_nr_divider_if #(.N(8))  if8 ();
    seq_nr_divider_if #(.N(32)) if32 ();

    seq_nr_divider #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_nr_divider #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    // Waits (bounded) for done; lat counts clock edges after the accepting edge.
    task automatic wait8(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!if8.done && lat < LIMIT) begin
            if (if8.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept8(input logic [7:0] dd, input logic [7:0] dv);
        if8.start = 1'b1; if8.dividend = dd; if8.divisor = dv;
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.dividend = 8'($urandom); if8.divisor = 8'($urandom);
    endtask

    task automatic test_reset;
        checks++;
        if ({if8.busy, if8.done, if8.div_by_zero, if8.quotient, if8.remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     if8.busy, if8.done, if8.div_by_zero, if8.quotient, if8.remainder);
        end
        checks++;
        if ({if32.busy, if32.done, if32.div_by_zero, if32.quotient, if32.remainder} !== 67'd0) begin
            errors++;
            $display("FAIL reset32: got busy=%b done=%b dbz=%b q=%0h r=%0h, want all 0",
                     if32.busy, if32.done, if32.div_by_zero, if32.quotient, if32.remainder);
        end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        accept8(8'd100, 8'd7);
        wait8(lat, bcnt);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
        checks++;
        if (bcnt !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", bcnt); end
        checks++;
        if (if8.quotient !== 8'd14 || if8.remainder !== 8'd2 || if8.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0",
                     if8.quotient, if8.remainder, if8.div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (if8.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done got %b want 0", if8.done); end
    endtask

    task automatic test_corners;
        logic [7:0] tab_dd [3] = '{8'd255, 8'd5, 8'd255};
        logic [7:0] tab_dv [3] = '{8'd1, 8'd9, 8'd255};
        logic [7:0] tab_q  [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] tab_r  [3] = '{8'd0, 8'd5, 8'd0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            accept8(tab_dd[i], tab_dv[i]);
            wait8(lat, bcnt);
            checks++;
            if (if8.quotient !== tab_q[i] || if8.remainder !== tab_r[i] || lat !== 9) begin
                errors++;
                $display("FAIL corner_%0d_%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9",
                         tab_dd[i], tab_dv[i], if8.quotient, if8.remainder, lat, tab_q[i], tab_r[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        @(posedge clk); #1;
        accept8(8'd200, 8'd0);
        wait8(lat, bcnt);
        checks++;
        if (lat !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL dz_timing: got lat=%0d busy_cycles=%0d want 0 0", lat, bcnt);
        end
        checks++;
        if (if8.div_by_zero !== 1'b1 || if8.quotient !== 8'd255 || if8.remainder !== 8'd200) begin
            errors++;
            $display("FAIL dz_result: got dbz=%b q=%0d r=%0d want dbz=1 q=255 r=200",
                     if8.div_by_zero, if8.quotient, if8.remainder);
        end
        @(posedge clk); #1;
        accept8(8'd9, 8'd3);
        wait8(lat, bcnt);
        checks++;
        if (if8.div_by_zero !== 1'b0 || if8.quotient !== 8'd3 || if8.remainder !== 8'd0) begin
            errors++;
            $display("FAIL dz_clear_9_3: got dbz=%b q=%0d r=%0d want dbz=0 q=3 r=0",
                     if8.div_by_zero, if8.quotient, if8.remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        @(posedge clk); #1;
        accept8(8'd100, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        if8.start = 1'b1; if8.dividend = 8'd50; if8.divisor = 8'd5;
        @(posedge clk); #1;
        if8.start = 1'b0;
        wait8(lat, bcnt);
        checks++;
        if (if8.quotient !== 8'd14 || if8.remainder !== 8'd2 || lat !== 5) begin
            errors++;
            $display("FAIL ignore_busy_start: got q=%0d r=%0d lat=%0d want q=14 r=2 lat=5",
                     if8.quotient, if8.remainder, lat);
        end
        if8.start = 1'b1; if8.dividend = 8'd50; if8.divisor = 8'd5;
        @(posedge clk); #1;
        if8.start = 1'b0;
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", if8.done, if8.busy);
        end
        wait8(lat, bcnt);
        checks++;
        if (if8.quotient !== 8'd10 || if8.remainder !== 8'd0 || lat !== 9) begin
            errors++;
            $display("FAIL b2b_50_5: got q=%0d r=%0d lat=%0d want q=10 r=0 lat=9",
                     if8.quotient, if8.remainder, lat);
        end
    endtask

    task automatic test_mid_reset;
        int lat, bcnt;
        int seen_done;
        @(posedge clk); #1;
        accept8(8'd100, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.div_by_zero, if8.quotient, if8.remainder} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     if8.busy, if8.done, if8.div_by_zero, if8.quotient, if8.remainder);
        end
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d done cycles want 0", seen_done); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept8(8'd77, 8'd8);
        wait8(lat, bcnt);
        checks++;
        if (if8.quotient !== 8'd9 || if8.remainder !== 8'd5) begin
            errors++;
            $display("FAIL after_reset_77_8: got q=%0d r=%0d want q=9 r=5", if8.quotient, if8.remainder);
        end
    endtask

    task automatic test_random32;
        logic [31:0] dd, dv, exp_q, exp_r;
        logic exp_z;
        int lat, exp_lat;
        for (int i = 0; i < 200; i++) begin
            dd = $urandom;
            case ($urandom_range(0, 3))
                0: dv = 32'($urandom_range(1, 255));
                1: dv = $urandom >> $urandom_range(0, 31);
                default: dv = $urandom;
            endcase
            if (i == 0) begin dd = 32'hFFFF_FFFF; dv = 32'hFFFF_FFFE; end
            if (i == 1) begin dd = 32'h1; dv = 32'hFFFF_FFFF; end
            if (i == 2) dv = 32'h0;
            exp_z   = (dv == 32'h0);
            exp_q   = exp_z ? 32'hFFFF_FFFF : dd / dv;
            exp_r   = exp_z ? dd : dd % dv;
            exp_lat = exp_z ? 0 : 33;

            @(posedge clk); #1;
            if32.start = 1'b1; if32.dividend = dd; if32.divisor = dv;
            @(posedge clk); #1;
            if32.start = 1'b0; if32.dividend = $urandom; if32.divisor = $urandom;
            lat = 0;
            while (!if32.done && lat < LIMIT) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL rand32_latency[%0d]: %0h/%0h got %0d want %0d", i, dd, dv, lat, exp_lat);
            end
            checks++;
            if (if32.quotient !== exp_q || if32.remainder !== exp_r || if32.div_by_zero !== exp_z) begin
                errors++;
                $display("FAIL rand32_result[%0d]: %0h/%0h got q=%0h r=%0h dbz=%b want q=%0h r=%0h dbz=%b",
                         i, dd, dv, if32.quotient, if32.remainder, if32.div_by_zero, exp_q, exp_r, exp_z);
            end
        end
    endtask

    initial begin
        if8.start = 1'b0;  if8.dividend = '0;  if8.divisor = '0;
        if32.start = 1'b0; if32.dividend = '0; if32.divisor = '0;
        rst_n = 1'b0;
        #1;
        test_reset;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic;
        test_corners;
        test_div_zero;
        test_back_to_back;
        test_mid_reset;
        test_random32;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
